// File: rtl/mfp_ahb_interconnect.sv
// AHB-lite single-master interconnect for MIPSfpga.
// Decodes HADDR onto N_SLV address-matched slave ports and muxes the selected
// slave's data-phase response back to the master. Unmapped active transfers
// get a two-cycle ERROR from a built-in default slave. A watchdog turns an
// over-long slave stall into the same two-cycle ERROR.
module mfp_ahb_interconnect #(
  parameter int                     N_SLV    = 7,
  parameter logic [N_SLV*32-1:0]    SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*32-1:0]    SLV_MASK = {N_SLV{32'h0}},
  parameter int                     TIMEOUT  = 255
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  output logic [N_SLV-1:0]    HSEL,
  input  logic [N_SLV*32-1:0] HRDATA_S,
  input  logic [N_SLV-1:0]    HREADYOUT_S,
  input  logic [N_SLV-1:0]    HRESP_S,
  output logic [31:0]         HRDATA,
  output logic                HREADY,
  output logic                HRESP,
  output logic                ERR_VALID,
  output logic                ERR_CODE,
  output logic [31:0]         ERR_ADDR
);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam bit          WDOG_EN    = (TIMEOUT != 0);
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_EN ? TIMEOUT - 1 : 0);

  state_t             state, state_nxt;
  logic [N_SLV-1:0]   sel_d;
  logic               act_d;
  logic [31:0]        addr_d;
  logic [15:0]        wcnt;
  logic               err_code;
  logic [31:0]        err_addr;

  logic               hready, hresp;
  logic [31:0]        hrdata;
  logic               slv_ready, slv_resp;
  logic [31:0]        slv_rdata;
  logic               slv_stall, wdog_hit, dec_err;
  logic               addr_match;
  logic               unused_htrans0;

  // HTRANS[0] only separates IDLE from BUSY and SEQ from NONSEQ; both pairs
  // are treated alike here.
  assign unused_htrans0 = HTRANS[0];

  // Address decode: lowest-index matching slave wins; a zero mask disables a port.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    HSEL       = '0;
    addr_match = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!addr_match && (SLV_MASK[32*i +: 32] != 32'h0) &&
          ((HADDR & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
        HSEL[i]    = 1'b1;
        addr_match = 1'b1;
      end
    end
  end

  // Data-phase response mux; sel_d is one-hot or zero so OR-ing is exact.
  always_comb begin
    slv_ready = 1'b0;
    slv_resp  = 1'b0;
    slv_rdata = 32'h0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_d[i]) begin
        slv_ready = slv_ready | HREADYOUT_S[i];
        slv_resp  = slv_resp  | HRESP_S[i];
        slv_rdata = slv_rdata | HRDATA_S[32*i +: 32];
      end
    end
  end

  assign slv_stall = (state == ST_SLV) && act_d && !slv_ready;
  assign wdog_hit  = WDOG_EN && slv_stall && (wcnt == WDOG_LIMIT);

  // Bus outputs per state and next-state selection.
  always_comb begin
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    state_nxt = state;
    case (state)
      ST_SLV: begin
        hready = slv_ready;
        hresp  = slv_resp;
        hrdata = slv_rdata;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase

    if (state == ST_ERR1)
      state_nxt = ST_ERR2;
    else if (hready)
      state_nxt = !HTRANS[1] ? ST_OK : (addr_match ? ST_SLV : ST_ERR1);
    else if (wdog_hit)
      state_nxt = ST_ERR1;
  end

  assign dec_err = hready && HTRANS[1] && !addr_match;

  // State, data-phase capture, watchdog count and error capture.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: every register here is control state, so all of it takes a reset value.
      state    <= ST_OK;
      sel_d    <= '0;
      act_d    <= 1'b0;
      addr_d   <= 32'h0;
      wcnt     <= 16'h0;
      err_code <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (hready) begin
        sel_d  <= HSEL;
        act_d  <= HTRANS[1];
        addr_d <= HADDR;
      end
      if (hready)
        wcnt <= 16'h0;
      else if (slv_stall)
        wcnt <= wcnt + 16'h1;
      // The decode-error address is the one being captured into addr_d now.
      if (dec_err) begin
        err_code <= 1'b0;
        err_addr <= HADDR;
      end else if (wdog_hit) begin
        err_code <= 1'b1;
        err_addr <= addr_d;
      end
    end
  end

  assign HREADY    = hready;
  assign HRESP     = hresp;
  assign HRDATA    = hrdata;
  assign ERR_VALID = (state == ST_ERR2);
  assign ERR_CODE  = err_code;
  assign ERR_ADDR  = err_addr;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Scoreboard bench for mfp_ahb_interconnect: four slave ports, TIMEOUT=4.
// Stimulus pushes one expected data-phase result per address phase; a
// monitor pops and compares each time a data phase completes.
module tb_mfp_ahb_interconnect;

  localparam int N  = 4;
  localparam int TO = 4;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [N-1:0]    HSEL;
  logic [N*32-1:0] HRDATA_S;
  logic [N-1:0]    HREADYOUT_S;
  logic [N-1:0]    HRESP_S;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic            ERR_VALID;
  logic            ERR_CODE;
  logic [31:0]     ERR_ADDR;

  mfp_ahb_interconnect #(
    .N_SLV    (N),
    .SLV_BASE ({32'h30000000, 32'h30000000, 32'h00000000, 32'h1fc00000}),
    .SLV_MASK ({32'hff000000, 32'hf0000000, 32'h10000000, 32'h1ff00000}),
    .TIMEOUT  (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .ERR_VALID   (ERR_VALID),
    .ERR_CODE    (ERR_CODE),
    .ERR_ADDR    (ERR_ADDR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        resp;
    logic        ev;
    int          waits;
    logic        wresp;
    bit          chk_err;
    logic        code;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   tag_pending = 1'b0;

  // Per-slave behaviour used by the responder.
  int          wait_cfg[N];
  logic [31:0] data_cfg[N];
  bit          err_cfg[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] rdata, input logic resp,
                              input logic ev, input int waits, input logic wresp,
                              input bit chk_err, input logic code, input logic [31:0] addr);
    exp_t e;
    e.name = name; e.rdata = rdata; e.resp = resp; e.ev = ev; e.waits = waits;
    e.wresp = wresp; e.chk_err = chk_err; e.code = code; e.addr = addr;
    return e;
  endfunction

  // Slave responder: starts a transfer on an HREADY=1 edge with an active,
  // selected address phase, then counts down its wait states.
  initial begin : responder
    bit rsp_busy = 1'b0;
    int rsp_cur  = 0;
    int rsp_rem  = 0;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        rsp_busy = 1'b0;
      end else if (HREADY) begin
        rsp_busy = 1'b0;
        if (HTRANS[1]) begin
          for (int i = 0; i < N; i++) begin
            if (HSEL[i]) begin
              rsp_busy = 1'b1;
              rsp_cur  = i;
              rsp_rem  = wait_cfg[i];
            end
          end
        end
      end else if (rsp_busy && rsp_rem > 0) begin
        rsp_rem--;
      end
      @(posedge HCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        HREADYOUT_S[i]       = 1'b1;
        HRESP_S[i]           = 1'b0;
        HRDATA_S[32*i +: 32] = 32'ha5a50000 | 32'(i);
      end
      if (rsp_busy) begin
        HREADYOUT_S[rsp_cur]       = (rsp_rem == 0);
        HRESP_S[rsp_cur]           = err_cfg[rsp_cur] && (rsp_rem <= 1);
        HRDATA_S[32*rsp_cur +: 32] = (rsp_rem == 0) ? data_cfg[rsp_cur] : 32'h0bad0bad;
      end
    end
  end

  // Monitor: a tagged data phase completes on the first HREADY=1 negedge after capture.
  initial begin : monitor
    bit   phase_valid = 1'b0;
    int   waits       = 0;
    logic last_resp   = 1'b0;
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (phase_valid && HREADY) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_rdata"}, HRDATA, e.rdata);
          check({e.name, "_resp"}, 32'(HRESP), 32'(e.resp));
          check({e.name, "_err_valid"}, 32'(ERR_VALID), 32'(e.ev));
          check({e.name, "_waits"}, 32'(waits), 32'(e.waits));
          if (e.waits > 0)
            check({e.name, "_wait_resp"}, 32'(last_resp), 32'(e.wresp));
          if (e.chk_err) begin
            check({e.name, "_err_code"}, 32'(ERR_CODE), 32'(e.code));
            check({e.name, "_err_addr"}, ERR_ADDR, e.addr);
          end
        end
      end else if (phase_valid) begin
        waits++;
        last_resp = HRESP;
      end
      if (HREADY) begin
        phase_valid = tag_pending;
        tag_pending = 1'b0;
        waits       = 0;
      end
    end
  end

  // Present one address phase, hold it until HREADY=1 captures it.
  task automatic issue(input logic [31:0] addr, input logic [1:0] trans,
                       input logic [N-1:0] exp_sel, input exp_t rec);
    int n = 0;
    HADDR  = addr;
    HTRANS = trans;
    sb_q.push_back(rec);
    tag_pending = 1'b1;
    @(negedge HCLK);
    check({rec.name, "_hsel"}, 32'(HSEL), 32'(exp_sel));
    while (!HREADY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!HREADY) check({rec.name, "_addr_phase_bound"}, 32'(HREADY), 32'd1);
    @(posedge HCLK);
    #2;
  endtask

  initial begin : stimulus
    int n;
    wait_cfg = '{0, 3, 1, 0};
    data_cfg = '{32'hdeadbeef, 32'h11111111, 32'h22222222, 32'h33333333};
    err_cfg  = '{1'b0, 1'b0, 1'b1, 1'b0};
    HRESETn = 1'b0;
    HADDR   = 32'h1fc00004;
    HTRANS  = 2'b00;

    // Reset state; HSEL stays live during reset.
    #12;
    check("rst_hready", 32'(HREADY), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_err_valid", 32'(ERR_VALID), 32'd0);
    check("rst_err_code", 32'(ERR_CODE), 32'd0);
    check("rst_err_addr", ERR_ADDR, 32'h0);
    check("rst_hsel_s0", 32'(HSEL), 32'h1);
    HADDR = 32'h30000010;
    #1;
    check("rst_hsel_overlap", 32'(HSEL), 32'h4);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    // Zero-wait read from slave 0.
    issue(32'h1fc00004, 2'b10, 4'b0001, mk("s0_read", 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0));
    // Slave 1 with three wait states, then slave 0 back to back.
    issue(32'h00000100, 2'b10, 4'b0010, mk("s1_wait3", 32'h11111111, 0, 0, 3, 0, 0, 0, 0));
    issue(32'h1fc00008, 2'b10, 4'b0001, mk("s0_after_s1", 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0));
    // Unmapped NONSEQ, then IDLE to the same address.
    issue(32'h1e000000, 2'b10, 4'b0000, mk("decode_err", 32'h0, 1, 1, 1, 1, 1, 0, 32'h1e000000));
    issue(32'h1e000000, 2'b00, 4'b0000, mk("idle_unmapped", 32'h0, 0, 0, 0, 0, 0, 0, 0));
    // Slave 1 stalls forever: TIMEOUT stall cycles plus ERR1.
    wait_cfg[1] = 32'h0000ffff;
    issue(32'h00000200, 2'b10, 4'b0010, mk("timeout", 32'h0, 1, 1, TO + 1, 1, 1, 1, 32'h00000200));
    wait_cfg[1] = 3;
    issue(32'h1fc0000c, 2'b10, 4'b0001, mk("s0_after_to", 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0));
    // Overlapping masks; slave 2 returns its own two-cycle ERROR.
    issue(32'h30000010, 2'b10, 4'b0100, mk("slv_error", 32'h22222222, 1, 0, 1, 1, 0, 0, 0));
    // BUSY is not active; SEQ is.
    issue(32'h00000300, 2'b01, 4'b0010, mk("busy", 32'h0, 0, 0, 0, 0, 0, 0, 0));
    issue(32'h1fc00010, 2'b11, 4'b0001, mk("seq_s0", 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 0));
    HTRANS = 2'b00;

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset pulse during ERR1.
    @(posedge HCLK);
    #2;
    HADDR  = 32'h1e000000;
    HTRANS = 2'b10;
    @(posedge HCLK);
    #2;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("err1_hready", 32'(HREADY), 32'd0);
    check("err1_hresp", 32'(HRESP), 32'd1);
    check("err1_err_addr", ERR_ADDR, 32'h1e000000);
    #1;
    HRESETn = 1'b0;
    #1;
    check("rst_err1_hready", 32'(HREADY), 32'd1);
    check("rst_err1_hresp", 32'(HRESP), 32'd0);
    check("rst_err1_err_valid", 32'(ERR_VALID), 32'd0);
    check("rst_err1_err_addr", ERR_ADDR, 32'h0);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      check("post_rst_err_valid", 32'(ERR_VALID), 32'd0);
      check("post_rst_hready", 32'(HREADY), 32'd1);
      check("post_rst_hresp", 32'(HRESP), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : time_bound
    #200000;
    $display("FAIL global_time_bound: got expired expected finish");
    $fatal(1, "time bound");
  end

endmodule

// File: doc/mfp_ahb_interconnect.md
# mfp_ahb_interconnect

Parametrised AHB-lite single-master interconnect for the MIPSfpga platform. It replaces the fixed seven-slave decoder/mux pair with N address-matched slave ports, per-slave wait-state and error propagation, a built-in default slave that returns a two-cycle ERROR for unmapped accesses, and a stall watchdog. It sits between the core's AHB-lite master port and the RAM, GPIO, seven-segment, heartbeat, timer and SPI peripherals.

## Interface

Parameters:
- N_SLV, 7: number of slave ports (1..16).
- SLV_BASE, {N_SLV{32'h0}}: packed N_SLV×32 base addresses; slave i uses bits [32i+31:32i].
- SLV_MASK, {N_SLV{32'h0}}: packed N_SLV×32 compare masks. Slave i matches when (HADDR & mask_i) == (base_i & mask_i). An all-zero mask disables slave i.
- TIMEOUT, 255: stall limit in cycles (1..65535). 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- HCLK  in  1  bus clock. All state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSEL  out  N_SLV  address-phase slave selects. Combinational one-hot or zero.
- HRDATA_S  in  N_SLV×32  packed slave read data.
- HREADYOUT_S  in  N_SLV  per-slave ready.
- HRESP_S  in  N_SLV  per-slave response.
- HRDATA  out  32  read data to the master.
- HREADY  out  1  bus ready. Drives the master and all slaves.
- HRESP  out  1  bus response.
- ERR_VALID  out  1  one-cycle pulse when the interconnect terminates a transfer.
- ERR_CODE  out  1  cause of termination: 0 = decode error, 1 = timeout. Held until the next error.
- ERR_ADDR  out  32  HADDR of the terminated transfer. Held until the next error.

## Operation

Address decode:
- HSEL[i] is asserted for the lowest-index matching slave only. If several slaves match, the lower index wins.
- HSEL is decoded from HADDR only. Slaves qualify it with HTRANS.
- An active transfer has HTRANS[1]=1.

Data-phase capture:
- On each rising edge where HREADY=1, the block registers sel_d (the HSEL value), act_d (HTRANS[1]) and addr_d (HADDR).
- While HREADY=0 these registers hold.

State machine (state: OK, SLV, ERR1, ERR2). On a HREADY=1 edge the next state is chosen as follows:
- Active transfer matched to slave i: go to SLV.
- Active transfer with no match: go to ERR1.
- Transfer not active (IDLE or BUSY): go to OK.

Outputs per state:
- OK: HREADY=1, HRESP=0, HRDATA=0.
- SLV: HRDATA, HREADY and HRESP are taken from slave sel_d. A slave's own two-cycle ERROR passes through unchanged.
- ERR1: HREADY=0, HRESP=1. Always moves to ERR2 on the next edge.
- ERR2: HREADY=1, HRESP=1, ERR_VALID=1. The next state comes from the address phase, as for any HREADY=1 edge.

Watchdog:
- A 16-bit counter wcnt counts up in SLV while HREADYOUT_S[sel_d]=0.
- wcnt clears on any HREADY=1 edge.
- When TIMEOUT≠0 and wcnt reaches TIMEOUT-1 with the slave still not ready, the next state is ERR1 with ERR_CODE=1.
- From that point the stalled slave's outputs are ignored for this transfer.
- The slave sees HREADY=1 in ERR2 and must treat that as the end of the transfer.

Error capture:
- ERR_ADDR and ERR_CODE load on entry to ERR1 (from addr_d and the cause).
- ERR_VALID is asserted only in ERR2.

## Timing

- Reset values: state=OK, sel_d=0, act_d=0, addr_d=0, wcnt=0. The outputs therefore reset to HREADY=1, HRESP=0, HRDATA=0, ERR_VALID=0, ERR_CODE=0, ERR_ADDR=0.
- HSEL follows HADDR combinationally during reset.
- Reset asserted mid-transfer (including in ERR1/ERR2) forces state OK immediately. No ERR_VALID pulse is produced.
- Zero-wait slave: data and OKAY are presented in the cycle after the address phase. The interconnect adds no cycles.
- Decode error: exactly two data-phase cycles, with HREADY low for one cycle.
- Timeout: the slave is low for TIMEOUT cycles, followed by ERR1 and then ERR2. The total data phase is TIMEOUT+2 cycles.
- Pipelining: the next address phase overlaps the current data phase and is captured on the edge where HREADY=1 (including the ERR2 edge).
- Combinational paths run from HREADYOUT_S/HRESP_S/HRDATA_S through the mux to HREADY/HRESP/HRDATA. No path runs from HADDR to HREADY.

## Test plan

- Base/mask map 0x1fc00000/0x1ff00000 (slave 0) and 0x00000000/0x10000000 (slave 1). NONSEQ read of 0x1fc00004, with slave 0 returning 0xdeadbeef at zero wait → HSEL=2'b01 in the address phase; the next cycle gives HRDATA=0xdeadbeef, HREADY=1, HRESP=0.
- Back-to-back reads to slave 1 then slave 0, with slave 1 adding 3 wait states → HREADY low for 3 cycles. The slave 0 address is held. Slave 0 data appears one cycle after slave 1 completes.
- NONSEQ to unmapped 0x1e000000 → ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1, ERR_VALID=1), with ERR_CODE=0 and ERR_ADDR=0x1e000000. An IDLE to the same address → OKAY with zero wait and no ERR_VALID.
- TIMEOUT=4, slave 1 holding HREADYOUT=0 forever → 4 stall cycles, then ERR1, then ERR2 with ERR_CODE=1. The following transfer to slave 0 completes normally.
- Overlapping masks on slaves 2 and 3 → only HSEL[2] asserts. Slave-driven ERROR (HRESP_S=1 with HREADYOUT 0 then 1) → passed through verbatim, with ERR_VALID=0.
- HRESETn pulsed low during ERR1 → immediately HREADY=1, HRESP=0, ERR_VALID never asserts, and the state is OK after release.
